// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART. The CPU writes bytes to transmit on TXD
// and polls status/data registers to drain a small receive FIFO fed from RXD.
// Bit timing is a per-direction down-counter that reloads on terminal count.
//
// state   | meaning (shared encoding for TX and RX machines)
// S_IDLE  | line idle, waiting for CPU write (TX) or falling edge (RX)
// S_START | start bit in progress (RX: waiting for mid-bit check)
// S_DATA  | eight data bits, LSB first
// S_STOP  | stop bit in progress
module uart_mmio #(
    parameter int          CLK_FREQ  = 60000000,
    parameter int          BAUD      = 9600,
    parameter int          RX_DEPTH  = 8,
    parameter logic [31:0] DATA_ADDR = 32'hBFD003F8,
    parameter logic [31:0] STAT_ADDR = 32'hBFD003FC
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE,
    input  logic        WE,
    input  logic [31:0] ADDR,
    input  logic [7:0]  WDATA,
    output logic [31:0] RDATA,
    input  logic        RXD,
    output logic        TXD
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int PW  = $clog2(RX_DEPTH);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // bus decode
    logic data_rd, stat_rd, data_wr;
    assign data_rd = CE & ~WE & (ADDR == DATA_ADDR);
    assign stat_rd = CE & ~WE & (ADDR == STAT_ADDR);
    assign data_wr = CE &  WE & (ADDR == DATA_ADDR);

    // ---------------- transmitter ----------------
    state_t        tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_tc, tx_start, tx_idle;

    assign tx_tc    = (tx_cnt == '0);
    assign tx_idle  = (tx_state == S_IDLE);
    assign tx_start = data_wr & tx_idle;

    // TX state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) tx_state <= S_IDLE;
        else        tx_state <= tx_next;
    end

    // TX next-state logic
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            S_IDLE:  if (tx_start) tx_next = S_START;
            S_START: if (tx_tc) tx_next = S_DATA;
            S_DATA:  if (tx_tc && tx_bit == 3'd7) tx_next = S_STOP;
            S_STOP:  if (tx_tc) tx_next = S_IDLE;
            default: tx_next = S_IDLE;
        endcase
    end

    // TX bit timer, bit index and shift register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else if (tx_start) begin
            tx_shift <= WDATA;
            tx_cnt   <= DIV_M1;
            tx_bit   <= '0;
        end else if (!tx_idle) begin
            if (tx_tc) begin
                tx_cnt <= DIV_M1;
                if (tx_state == S_DATA) begin
                    tx_shift <= {1'b0, tx_shift[7:1]};
                    tx_bit   <= tx_bit + 3'd1;
                end
            end else begin
                tx_cnt <= tx_cnt - CW'(1);
            end
        end
    end

    // registered line driver; idles high and is forced high by reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) TXD <= 1'b1;
        else begin
            case (tx_state)
                S_START: TXD <= 1'b0;
                S_DATA:  TXD <= tx_shift[0];
                default: TXD <= 1'b1;
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic          rxd_s1, rxd_s2, rxd_prev, rx_fall;
    state_t        rx_state, rx_next;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_tc, push_req;

    // synchroniser plus one delay flop for edge detection; all idle high
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_s1   <= RXD;
            rxd_s2   <= rxd_s1;
            rxd_prev <= rxd_s2;
        end
    end

    assign rx_fall  = rxd_prev & ~rxd_s2;
    assign rx_tc    = (rx_cnt == '0);
    assign push_req = (rx_state == S_STOP) & rx_tc & rxd_s2;

    // RX state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) rx_state <= S_IDLE;
        else        rx_state <= rx_next;
    end

    // RX next-state logic; a high mid-start sample is a glitch
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:  if (rx_fall) rx_next = S_START;
            S_START: if (rx_tc) rx_next = rxd_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (rx_tc && rx_bit == 3'd7) rx_next = S_STOP;
            S_STOP:  if (rx_tc) rx_next = S_IDLE;
            default: rx_next = S_IDLE;
        endcase
    end

    // RX bit timer (half period to mid-start, then full periods) and shifter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else if (rx_state == S_IDLE) begin
            rx_bit <= '0;
            if (rx_fall) rx_cnt <= HALF_M1;
        end else if (rx_tc) begin
            rx_cnt <= DIV_M1;
            if (rx_state == S_DATA) begin
                rx_shift <= {rxd_s2, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
        end else begin
            rx_cnt <= rx_cnt - CW'(1);
        end
    end

    // ---------------- receive FIFO ----------------
    logic [7:0]  fifo_mem [RX_DEPTH];
    logic [PW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, push, overrun, ovr_set;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop   = data_rd & ~empty;
    // a pop in the same cycle frees the slot, so a push into a full FIFO survives
    assign push    = push_req & (~full | pop);
    assign ovr_set = push_req & full & ~pop;

    // FIFO pointers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage; contents are don't-care while empty
    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr[PW-1:0]] <= rx_shift;
    end

    // sticky overrun; a fresh overrun wins over the status-read clear
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)       overrun <= 1'b0;
        else if (ovr_set) overrun <= 1'b1;
        else if (stat_rd) overrun <= 1'b0;
    end

    // combinational read mux
    always_comb begin
        RDATA = '0;
        if (ADDR == DATA_ADDR) begin
            if (!empty) RDATA = {24'b0, fifo_mem[rd_ptr[PW-1:0]]};
        end else if (ADDR == STAT_ADDR) begin
            RDATA = {29'b0, overrun, ~empty, tx_idle};
        end
    end
endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: directed bench for uart_mmio at DIV=16, 4-entry RX FIFO.
module tb_uart_mmio;
    localparam logic [31:0] DATA_A = 32'hBFD003F8;
    localparam logic [31:0] STAT_A = 32'hBFD003FC;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        CE = 1'b0;
    logic        WE = 1'b0;
    logic [31:0] ADDR = 32'h0;
    logic [7:0]  WDATA = 8'h0;
    logic [31:0] RDATA;
    logic        RXD = 1'b1;
    logic        TXD;

    int n_cmp = 0;
    int n_bad = 0;

    uart_mmio #(
        .CLK_FREQ (16),
        .BAUD     (1),
        .RX_DEPTH (4),
        .DATA_ADDR(DATA_A),
        .STAT_ADDR(STAT_A)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .CE   (CE),
        .WE   (WE),
        .ADDR (ADDR),
        .WDATA(WDATA),
        .RDATA(RDATA),
        .RXD  (RXD),
        .TXD  (TXD)
    );

    always #5 CLK = ~CLK;

    initial begin
        #10000000;
        $display("FAIL watchdog: run did not finish, got timeout, want finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // all bus tasks start and end on a falling clock edge
    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        CE = 1'b1; WE = 1'b0; ADDR = a;
        #1 d = RDATA;
        @(negedge CLK);
        CE = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
        CE = 1'b1; WE = 1'b1; ADDR = a; WDATA = d;
        @(negedge CLK);
        CE = 1'b0; WE = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RXD = f[i];
            repeat (16) @(negedge CLK);
        end
        RXD = 1'b1;
    endtask

    logic [31:0] rd;
    logic [9:0]  exp_a5;
    logic [9:0]  frm6;
    int          zeros;

    initial begin
        exp_a5 = 10'b1_10100101_0;   // stop, A5 msb..lsb, start
        frm6   = 10'b1_10010110_0;   // frame for 8'h96, interrupted by reset

        // 1: reset state
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        bus_read(STAT_A, rd);  check_eq("reset_stat", rd, 32'h1);
        check_eq("reset_txd", {31'b0, TXD}, 32'h1);
        bus_read(DATA_A, rd);  check_eq("reset_data", rd, 32'h0);
        bus_read(32'h0, rd);   check_eq("other_addr", rd, 32'h0);

        // 2: transmit A5, ignored write mid-frame
        CE = 1'b1; WE = 1'b1; ADDR = DATA_A; WDATA = 8'hA5;
        zeros = 0;
        for (int c = 1; c <= 240; c++) begin
            @(negedge CLK);
            CE = 1'b0; WE = 1'b0; ADDR = STAT_A;
            if (c == 50) begin
                CE = 1'b1; WE = 1'b1; ADDR = DATA_A; WDATA = 8'hFF;
            end
            #1;
            if (c >= 2 && c < 162 && ((c - 2) % 16) == 8)
                check_eq($sformatf("tx_bit%0d", (c - 2) / 16), {31'b0, TXD},
                         {31'b0, exp_a5[(c - 2) / 16]});
            if (c == 1)   check_eq("tx_busy_c1",   RDATA & 32'h1, 32'h0);
            if (c == 100) check_eq("tx_busy_c100", RDATA & 32'h1, 32'h0);
            if (c == 160) check_eq("tx_busy_c160", RDATA & 32'h1, 32'h0);
            if (c == 161) check_eq("tx_idle_c161", RDATA & 32'h1, 32'h1);
            if (c > 161 && TXD == 1'b0) zeros++;
        end
        check_eq("no_second_frame", zeros, 32'h0);
        @(negedge CLK);

        // 3: receive 3C
        send_rx(8'h3C, 1'b1);
        repeat (4) @(negedge CLK);
        bus_read(STAT_A, rd);  check_eq("rx_stat_avail", rd, 32'h3);
        bus_read(DATA_A, rd);  check_eq("rx_data_3c", rd, 32'h3C);
        bus_read(STAT_A, rd);  check_eq("rx_stat_empty", rd, 32'h1);

        // 4: overrun with five frames into a 4-deep FIFO
        for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1);
        repeat (4) @(negedge CLK);
        bus_read(STAT_A, rd);  check_eq("ovr_stat", rd, 32'h7);
        bus_read(STAT_A, rd);  check_eq("ovr_cleared", rd, 32'h3);
        for (int i = 1; i <= 4; i++) begin
            bus_read(DATA_A, rd);
            check_eq($sformatf("drain%0d", i), rd, 32'(i));
        end
        bus_read(DATA_A, rd);  check_eq("drain_empty", rd, 32'h0);
        bus_read(STAT_A, rd);  check_eq("drain_stat", rd, 32'h1);

        // 5: short glitch and framing error
        RXD = 1'b0;
        repeat (4) @(negedge CLK);
        RXD = 1'b1;
        repeat (40) @(negedge CLK);
        bus_read(STAT_A, rd);  check_eq("glitch_stat", rd, 32'h1);
        send_rx(8'h5A, 1'b0);
        repeat (20) @(negedge CLK);
        bus_read(STAT_A, rd);  check_eq("frame_err_stat", rd, 32'h1);
        bus_read(DATA_A, rd);  check_eq("frame_err_data", rd, 32'h0);

        // 6: reset during TX bit 3 (byte 00) and RX bit 5
        for (int c = 0; c < 104; c++) begin
            RXD = frm6[c / 16];
            CE = (c == 32); WE = (c == 32); ADDR = DATA_A; WDATA = 8'h00;
            if (c == 103) begin
                #1 check_eq("txd_low_before_rst", {31'b0, TXD}, 32'h0);
            end
            @(negedge CLK);
        end
        CE = 1'b0; WE = 1'b0;
        RST_N = 1'b0; RXD = 1'b1;
        #1 check_eq("txd_high_in_rst", {31'b0, TXD}, 32'h1);
        ADDR = STAT_A;
        #1 check_eq("rst_stat_comb", RDATA, 32'h1);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (20) @(negedge CLK);
        bus_read(STAT_A, rd);  check_eq("post_rst_stat", rd, 32'h1);
        send_rx(8'hC3, 1'b1);
        repeat (4) @(negedge CLK);
        bus_read(STAT_A, rd);  check_eq("post_rst_avail", rd, 32'h3);
        bus_read(DATA_A, rd);  check_eq("post_rst_c3", rd, 32'hC3);
        bus_read(STAT_A, rd);  check_eq("post_rst_final", rd, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
